// File: rtl/bram_arb_pkg.sv
// Shared state type and sizing helpers for bram_port_arbiter and its round-robin picker.
package bram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Requester ids need at least one bit even for a single requester.
    function automatic int idWidth(input int nReq);
        return (clog2(nReq) < 1) ? 1 : clog2(nReq);
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_rrPtr, wrapping modulo N_REQ.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = idWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_rrPtr,
    output logic [ID_W-1:0]  o_winner,
    output logic             o_anyValid
);

    int              w_sum;
    logic [ID_W-1:0] w_idx;

    // Scanning from the far end downward lets the closest candidate overwrite the others.
    always_comb begin
        o_winner   = '0;
        o_anyValid = |i_req;
        w_sum      = 0;
        w_idx      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = int'(i_rrPtr) + k;
            if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
            w_idx = ID_W'(w_sum);
            if (i_req[w_idx]) o_winner = w_idx;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin burst arbiter in front of one port of a write-first, registered-read BRAM.
// Define BRAM_ARB_OUT_REG_EN to add one register stage on the read response (latency 2).
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int  N_REQ      = 4,
    parameter int  ADDR_WIDTH = 8,
    parameter int  DATA_WIDTH = 64,
    parameter int  MAX_BURST  = 4,
    localparam int ID_W       = idWidth(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_din,
    output logic                        resp_valid,
    output logic [ID_W-1:0]             resp_id,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_din,
    output logic                        ram_en,
    output logic                        ram_we,
    input  logic [DATA_WIDTH-1:0]       ram_dout
);

    localparam int CNT_W = clog2(MAX_BURST + 1);

    state_t           r_state, w_stateNext;
    logic [ID_W-1:0]  r_grantQ, w_grantNext;
    logic [ID_W-1:0]  r_rrPtr, w_rrPtrNext;
    logic [CNT_W-1:0] r_beatCnt, w_beatCntNext;

    logic                  w_inGrant, w_active, w_beat, w_readBeat, w_release;
    logic [N_REQ-1:0]      w_grantOneHot, w_pickReq;
    logic [ID_W-1:0]       w_nextPtr, w_pickPtr, w_winner;
    logic                  w_anyValid;
    logic [ADDR_WIDTH-1:0] w_gAddr;
    logic [DATA_WIDTH-1:0] w_gDin;

    assign w_inGrant     = (r_state == GRANT);
    assign w_active      = w_inGrant && !rst;
    assign w_grantOneHot = N_REQ'(1) << r_grantQ;
    assign w_beat        = w_active && req_valid[r_grantQ];
    assign w_readBeat    = w_beat && !req_we[r_grantQ];
    assign w_gAddr       = req_addr[int'(r_grantQ)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_gDin        = req_din[int'(r_grantQ)*DATA_WIDTH +: DATA_WIDTH];
    assign w_nextPtr     = (int'(r_grantQ) == N_REQ - 1) ? '0 : r_grantQ + ID_W'(1);
    assign w_release     = w_inGrant &&
                           ((w_beat && (r_beatCnt == CNT_W'(MAX_BURST - 1))) || !req_valid[r_grantQ]);

    // On release the current owner is masked out so it only wins again via IDLE, after the others.
    assign w_pickReq = w_inGrant ? (req_valid & ~w_grantOneHot) : req_valid;
    assign w_pickPtr = w_inGrant ? w_nextPtr : r_rrPtr;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rrPick (
        .i_req      (w_pickReq),
        .i_rrPtr    (w_pickPtr),
        .o_winner   (w_winner),
        .o_anyValid (w_anyValid)
    );

    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grantQ;
        w_rrPtrNext   = r_rrPtr;
        w_beatCntNext = r_beatCnt;
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_stateNext   = GRANT;
                    w_grantNext   = w_winner;
                    w_beatCntNext = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_rrPtrNext   = w_nextPtr;
                    w_beatCntNext = '0;
                    if (w_anyValid) begin
                        w_grantNext = w_winner;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else if (w_beat) begin
                    w_beatCntNext = r_beatCnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grantQ  <= '0;
            r_rrPtr   <= '0;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_grantQ  <= w_grantNext;
            r_rrPtr   <= w_rrPtrNext;
            r_beatCnt <= w_beatCntNext;
        end
    end

    assign req_ready = w_active ? w_grantOneHot : '0;
    assign ram_en    = w_beat;
    assign ram_we    = w_beat && req_we[r_grantQ];
    assign ram_addr  = w_beat ? w_gAddr : '0;
    assign ram_din   = w_beat ? w_gDin : '0;

    logic                  r_respValid;
    logic [ID_W-1:0]       r_respId;
    logic                  w_s1Valid;
    logic [ID_W-1:0]       w_s1Id;
    logic [DATA_WIDTH-1:0] w_s1Data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_respValid <= 1'b0;
            r_respId    <= '0;
        end else begin
            r_respValid <= w_readBeat;
            if (w_readBeat) r_respId <= r_grantQ;
        end
    end

    // RAM data is already registered, so the first stage only tags it; reset kills it in flight.
    assign w_s1Valid = r_respValid && !rst;
    assign w_s1Id    = rst ? '0 : r_respId;
    assign w_s1Data  = w_s1Valid ? ram_dout : '0;

`ifdef BRAM_ARB_OUT_REG_EN
    logic                  r_outValid;
    logic [ID_W-1:0]       r_outId;
    logic [DATA_WIDTH-1:0] r_outData;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outId    <= '0;
            r_outData  <= '0;
        end else begin
            r_outValid <= w_s1Valid;
            r_outId    <= w_s1Id;
            r_outData  <= w_s1Data;
        end
    end

    assign resp_valid = r_outValid;
    assign resp_id    = r_outId;
    assign resp_data  = r_outData;
`else
    assign resp_valid = w_s1Valid;
    assign resp_id    = w_s1Id;
    assign resp_data  = w_s1Data;
`endif

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Round-robin arbiter sharing one port of a dual-port block RAM (write-first, registered read, 1-cycle latency) between N_REQ requesters.
- Grants are held for bursts of up to MAX_BURST beats, so streaming requesters keep the port without re-arbitration.
- Read data is returned on a shared response bus, tagged with the requester id.
- One instance sits in front of each RAM port; the RAM clock is tied to clk outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 64, RAM data width.
- MAX_BURST, 4, maximum beats per grant (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_ready  out  N_REQ  per-requester accept, at most one bit set.
- req_we  in  N_REQ  1 = write beat, 0 = read beat.
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_din  in  N_REQ*DATA_WIDTH  packed write data.
- resp_valid  out  1  read data valid.
- resp_id  out  ID_W  requester owning resp_data; ID_W = max(1, clog2(N_REQ)).
- resp_data  out  DATA_WIDTH  read data.
- ram_addr  out  ADDR_WIDTH  to RAM port addr.
- ram_din  out  DATA_WIDTH  to RAM port din.
- ram_en  out  1  to RAM port en.
- ram_we  out  1  to RAM port we.
- ram_dout  in  DATA_WIDTH  from RAM port dout.

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - outputs: req_ready=0, resp_valid=0, resp_id=0, resp_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
  - state: state=IDLE, rr_ptr=0, beat_cnt=0.
- States: IDLE, GRANT.
  - grant_q holds the registered winner index.
  - req_ready = onehot(grant_q) in GRANT, else 0.
- Arbitration:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo N_REQ.
  - IDLE with any req_valid: state=GRANT, grant_q=winner, beat_cnt=0. One-cycle arbitration latency; no beat is accepted in this cycle.
- Beat: req_valid[g] & req_ready[g] in GRANT.
  - Same cycle, combinational: ram_en=1, ram_we=req_we[g], ram_addr=slice g, ram_din=slice g.
  - Otherwise ram_en=0, ram_we=0.
  - beat_cnt increments per beat (width clog2(MAX_BURST+1)).
- Release: in GRANT, release when either (a) a beat occurs with beat_cnt==MAX_BURST-1, or (b) req_valid[g]=0 (no beat that cycle).
  - On release: rr_ptr=(g+1) mod N_REQ.
  - If any other requester is valid in the release cycle, pick a winner from the new rr_ptr, load grant_q directly and stay in GRANT with beat_cnt=0 (no idle bubble). Else go to IDLE.
  - A released requester still valid is eligible again only after the others, per round-robin order.
- Response:
  - A read beat in cycle t gives resp_valid=1, resp_id=g, resp_data=ram_dout in cycle t+1.
  - Write beats produce no response.
  - Responses have no backpressure; requesters must sink them.
- Throughput: one beat per cycle while the grant is held.
- Reset mid-operation: grant dropped immediately; the in-flight read response is discarded (resp_valid=0 the cycle after rst).
- Write-first RAM: a read beat to an address written by the previous beat returns the new data; the arbiter adds no forwarding.

Optional Feature:
- Macro BRAM_ARB_OUT_REG_EN.
  - Defined: resp_valid/resp_id/resp_data pass through one extra register stage; read latency becomes 2 cycles after the beat; reset clears the stage.
  - Undefined: latency 1 as above.

Decomposition:
- Package bram_arb_pkg:
  - state enum (IDLE, GRANT).
  - function clog2.
  - ID_W derivation helper.
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs winner index and any_valid. It is used for both IDLE and release arbitration.

Test Plan:
- Single requester 0 reads addr 8'h10 (pre-written 64'hA5): ready at cycle 1; resp_valid, id=0, data=64'hA5 at cycle 2 (cycle 3 with BRAM_ARB_OUT_REG_EN).
- MAX_BURST=4, requesters 0 and 2 continuously valid: grant pattern 0×4, 2×4, 0×4; no bubble cycles between bursts after the first.
- Requester 1 writes 64'hDEAD to 8'h20, then reads 8'h20 the next cycle: resp data=64'hDEAD, id=1.
- Requester 3 drops valid after 2 beats while 0 is waiting: release that cycle, 0 granted next cycle, rr_ptr=0.
- rst pulsed 1 cycle right after a read beat: resp_valid stays 0, req_ready=0, next grant goes to the lowest valid index.
- All four valid, MAX_BURST=1: grants rotate 0,1,2,3,0 with one beat per cycle and resp_id matching each read.
